// File: rtl/challenge_pkg.sv
// Shared types and constants for the challenge-response scheduling path.
package challenge_pkg;

  localparam int CHAL_W = 128;
  localparam int STIR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STIR    = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/challenge_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational scan from a registered pointer; the pointer
// moves past the served index when the owner releases the resource.
module rr_arbiter
  import challenge_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          update,
  input  logic [IW-1:0] served,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          found
);

  logic [IW-1:0] ptr;

  // NOTE: every output gets a default before the scan, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    int cand;
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!found && req[cand]) begin
        found           = 1'b1;
        grant_idx       = IW'(cand);
        grant_oh[cand]  = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (int'(served) == N - 1) ? '0 : served + IW'(1);
    end
  end

endmodule

// File: rtl/challenge_scheduler.sv
// Shares the 128-bit LFSR among requesters: grants round-robin, stirs the LFSR,
// captures one challenge and presents it on a valid/ready handshake.
module challenge_scheduler
  import challenge_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int STIR_CYCLES = 16,
  parameter int SEQ_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               lfsr_enable,
  input  logic [CHAL_W-1:0]  lfsr_random,
  output logic               chal_valid,
  input  logic               chal_ready,
  output logic [CHAL_W-1:0]  chal_data,
  output logic [1:0]         chal_id,
  output logic [SEQ_W-1:0]   chal_seq,
  output logic               busy
);

  localparam int IW = id_width(NUM_REQ);

  state_t                state, state_nxt;
  logic [STIR_CNT_W-1:0] stir_cnt;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [IW-1:0]         arb_idx;
  logic                  arb_found;
  logic                  handshake;

  assign handshake = (state == PRESENT) && chal_ready;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .update    (handshake),
    .served    (chal_id[IW-1:0]),
    .grant_oh  (arb_grant),
    .grant_idx (arb_idx),
    .found     (arb_found)
  );

  always_comb begin
    state_nxt   = state;
    lfsr_enable = 1'b0;
    chal_valid  = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:    if (arb_found) state_nxt = STIR;
      STIR: begin
        lfsr_enable = 1'b1;
        if (stir_cnt == '0) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = PRESENT;
      PRESENT: begin
        chal_valid = 1'b1;
        if (chal_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: chal_data is an ordinary output register, not a memory, so it is
  // reset along with the rest; a reset also discards any pending challenge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      chal_id   <= '0;
      chal_seq  <= '0;
      chal_data <= '0;
      stir_cnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant    <= arb_grant;
            chal_id  <= 2'(arb_idx);
            stir_cnt <= STIR_CNT_W'(STIR_CYCLES - 1);
          end
        end
        STIR: begin
          if (stir_cnt != '0) stir_cnt <= stir_cnt - 1'b1;
        end
        CAPTURE: chal_data <= lfsr_random;
        PRESENT: begin
          // Sequence number wraps naturally at 2^SEQ_W.
          if (chal_ready) begin
            grant    <= '0;
            chal_seq <= chal_seq + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/challenge_scheduler.md
Name: challenge_scheduler

Overview:
Sequences the 128-bit LFSR for the challenge-response path and shares it among NUM_REQ requesters.
- Arbitrates requests round-robin.
- Stirs the LFSR for STIR_CYCLES shifts so consecutive challenges are decorrelated.
- Captures one 128-bit challenge and presents it on a valid/ready handshake, tagged with the requester id and a sequence number.
- Sits between the LFSR (owns its enable) and the protocol/UART front-ends.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..4).
STIR_CYCLES, 16, LFSR shifts per challenge (legal 1..255).
SEQ_W, 16, width of challenge sequence counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
req  in  NUM_REQ  per-requester challenge request (level).
grant  out  NUM_REQ  one-hot current owner; 0 when idle.
lfsr_enable  out  1  shift enable to LFSR.
lfsr_random  in  128  LFSR state.
chal_valid  out  1  challenge available.
chal_ready  in  1  consumer accepts challenge.
chal_data  out  128  captured challenge.
chal_id  out  2  index of requester served.
chal_seq  out  SEQ_W  sequence number of presented challenge.
busy  out  1  state != IDLE.

Behaviour:
- Reset (rst high at clock edge) sets all outputs to 0: grant, lfsr_enable, chal_valid, chal_data, chal_id, chal_seq, busy. State=IDLE, RR pointer=0, stir counter=0. The LFSR is reset by the same rst externally; this block never resets it.
- FSM states: IDLE, STIR, CAPTURE, PRESENT.
- IDLE:
  - If req != 0, select the first asserted req scanning from the RR pointer upward, mod NUM_REQ.
  - Register grant (one-hot) and chal_id; load stir counter with STIR_CYCLES-1; go to STIR.
  - req == 0: remain in IDLE.
- STIR: lfsr_enable=1 every cycle, exactly STIR_CYCLES cycles. Counter decrements; at 0, go to CAPTURE.
- CAPTURE: one cycle, lfsr_enable=0. At the end of the cycle, chal_data <= lfsr_random, i.e. the state after exactly STIR_CYCLES shifts. Go to PRESENT.
- PRESENT:
  - chal_valid=1. chal_data, chal_id, chal_seq and grant are held stable until handshake.
  - On chal_valid && chal_ready: chal_valid drops next cycle, chal_seq increments (wraps 2^SEQ_W-1 -> 0), RR pointer <= served index+1 mod NUM_REQ, grant <= 0, go to IDLE.
- lfsr_enable is 0 in every state except STIR.
- Latency: req seen in IDLE at cycle 0 -> chal_valid high in cycle STIR_CYCLES+2.
- Minimum issue interval is STIR_CYCLES+3 cycles. There is no back-to-back bypass; IDLE is always visited for at least one cycle.
- Request deassertion after grant does not abort; the challenge is still delivered.
- Requests arriving while busy wait. Priority is re-evaluated only in IDLE.
- chal_data holds its last value after handshake until the next CAPTURE.
- rst mid-STIR/CAPTURE/PRESENT aborts immediately: all outputs 0 next cycle, pending challenge discarded, chal_seq back to 0.
- busy = (state != IDLE).

Decomposition:
- Package challenge_pkg holds:
  - state enum {IDLE, STIR, CAPTURE, PRESENT}
  - CHAL_W=128
  - a clog2-based id-width helper
- Sub-module rr_arbiter (combinational priority scan from pointer plus registered pointer) is natural and reusable by other shared resources.

Test Plan:
1. rst held 2 cycles, req=0 -> grant=0, lfsr_enable=0, chal_valid=0, chal_seq=0, busy=0.
2. STIR_CYCLES=4, NUM_REQ=2, req=2'b01 pulsed in cycle 0, chal_ready=1:
   - grant=01 and lfsr_enable=1 in cycles 1-4; lfsr_enable=0 in cycle 5.
   - chal_valid=1 in cycle 6.
   - chal_data equals the LFSR model advanced 4 steps from its seed; chal_id=0, chal_seq=0.
3. req=2'b11 held, chal_ready=1 -> served ids 0,1,0,1; chal_seq 0,1,2,3; each chal_data matches the model advanced 4 further steps; issue interval exactly 7 cycles.
4. Backpressure: chal_ready=0 for 10 cycles in PRESENT -> chal_valid, chal_data, chal_id, chal_seq stable, lfsr_enable=0 throughout. chal_ready=1 -> chal_valid=0 the next cycle.
5. rst asserted in the 2nd STIR cycle -> next cycle all outputs 0. A subsequent req=2'b10 is served with chal_id=1, chal_seq=0, chal_data = model advanced 4 steps from seed.
6. 65537 handshakes from requester 0 -> chal_seq reaches 65535, then wraps to 0.
